median3_filter: RTL and testbench

MEDIAN3_FILTER -- requirements
Module: median3_filter

---
 rtl/median_pkg.sv | 15 +
 rtl/median3_filter_if.sv | 30 +++
 rtl/median3_core.sv | 25 ++
 rtl/median3_filter.sv | 105 ++++++++++
 tb/tb_median3_filter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the 3-tap median filter.
//   DATA_W       : sample width
//   fill_state_e : window fill level; the encoding doubles as the sample count
package median_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2,
      FULL  = 2'd3
   } fill_state_e;

endpackage

// File: rtl/median3_filter_if.sv
// Streaming bundle for median3_filter.
//   in_valid/in_data/in_ready    : upstream sample handshake
//   flush                        : synchronous window discard
//   out_valid/out_data/out_ready : downstream result handshake
//   win_cnt                      : samples currently held in the window
// slave  : the filter side
// master : the source/sink side
interface median3_filter_if;
   import median_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              flush;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic [1:0]        win_cnt;

   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, win_cnt
   );

   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, win_cnt
   );

endinterface

// File: rtl/median3_core.sv
// Purely combinational unsigned median of three.
//   a_i, b_i, c_i : operands
//   med_o         : median value; with a repeated operand the repeat wins
module median3_core
   import median_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] c_i,
   output logic [DATA_W-1:0] med_o
);

   logic [DATA_W-1:0] lo_ab;
   logic [DATA_W-1:0] hi_ab;
   logic [DATA_W-1:0] hi_c;

   // median = max(min(a,b), min(max(a,b), c))
   always_comb begin
      lo_ab = (a_i < b_i) ? a_i : b_i;
      hi_ab = (a_i < b_i) ? b_i : a_i;
      hi_c  = (hi_ab < c_i) ? hi_ab : c_i;
      med_o = (lo_ab < hi_c) ? hi_c : lo_ab;
   end

endmodule

// File: rtl/median3_filter.sv
// Sliding 3-sample median filter with valid/ready handshakes on both sides.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : median3_filter_if.slave (sample in, result out, flush, win_cnt)
//
// state | meaning
// EMPTY | no samples in window
// ONE   | one sample in window
// TWO   | two samples in window
// FULL  | three samples; every further accept yields a result
module median3_filter
   import median_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   median3_filter_if.slave   bus
);

   fill_state_e       state_q, state_d;
   logic [DATA_W-1:0] w0_q, w1_q, w2_q;
   logic [DATA_W-1:0] w0_d, w1_d, w2_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              in_ready;
   logic              accept;
   logic              load;
   logic [DATA_W-1:0] median;

   // flush blocks acceptance, so it cannot combine with a new sample
   assign in_ready = (~out_valid_q | bus.out_ready) & ~bus.flush;
   assign accept   = bus.in_valid & in_ready;

   // median of the incoming sample and the two that shift into w1/w2
   median3_core u_core (
      .a_i   (bus.in_data),
      .b_i   (w0_q),
      .c_i   (w1_q),
      .med_o (median)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = EMPTY;
      end else if (accept) begin
         case (state_q)
            EMPTY:   state_d = ONE;
            ONE:     state_d = TWO;
            default: state_d = FULL;
         endcase
      end
   end

   always_comb begin
      w0_d        = w0_q;
      w1_d        = w1_q;
      w2_d        = w2_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      load        = accept & ((state_q == TWO) | (state_q == FULL));

      if (accept) begin
         w0_d = bus.in_data;
         w1_d = w0_q;
         w2_d = w1_q;
      end

      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = median;
      end else if (out_valid_q & bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w0_q        <= '0;
         w1_q        <= '0;
         w2_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         w2_q        <= w2_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.win_cnt   = state_q;

endmodule

// File: tb/tb_median3_filter.sv
module tb_median3_filter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   median3_filter_if ifc ();

   median3_filter dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [7:0] sb[$];
   logic [7:0] mw0, mw1;
   int         m_cnt;
   logic       m_ov;
   int         n_results;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_med(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
      if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
      return c;
   endfunction

   task automatic model_clear();
      sb.delete();
      m_cnt = 0;
      m_ov  = 1'b0;
      mw0   = 8'h00;
      mw1   = 8'h00;
   endtask

   // called with clk low and inputs already driven; advances one cycle
   task automatic tick();
      logic m_ready, acc, hs, ld;
      #1;
      m_ready = (~m_ov | ifc.out_ready) & ~ifc.flush;
      check_eq("in_ready", ifc.in_ready, m_ready);
      if (m_ov) begin
         if (sb.size() == 0) check_eq("sb_underflow", 1, 0);
         else                check_eq("out_data", ifc.out_data, sb[0]);
      end
      acc = ifc.in_valid & m_ready & ~rst;
      hs  = m_ov & ifc.out_ready & ~rst;
      ld  = acc & (m_cnt >= 2);
      if (hs && sb.size() > 0) void'(sb.pop_front());
      if (ld) begin
         sb.push_back(ref_med(ifc.in_data, mw0, mw1));
         n_results++;
      end
      if (acc) begin
         mw1 = mw0;
         mw0 = ifc.in_data;
      end
      if (!rst) begin
         if (ifc.flush)  m_cnt = 0;
         else if (acc)   m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
         if (ld)         m_ov = 1'b1;
         else if (hs)    m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
      check_eq("out_valid", ifc.out_valid, m_ov);
      check_eq("win_cnt", ifc.win_cnt, m_cnt);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d);
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      tick();
      ifc.in_valid = 1'b0;
   endtask

   initial begin
      int base;
      n_checks = 0;
      n_errors = 0;
      n_results = 0;
      model_clear();
      rst           = 1'b1;
      ifc.in_valid  = 1'b0;
      ifc.in_data   = 8'h00;
      ifc.flush     = 1'b0;
      ifc.out_ready = 1'b1;

      // reset values
      #2;
      check_eq("rst_out_valid", ifc.out_valid, 0);
      check_eq("rst_win_cnt", ifc.win_cnt, 0);
      check_eq("rst_out_data", ifc.out_data, 0);
      check_eq("rst_in_ready", ifc.in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // fill: 10, 30, 20
      send(8'd10);
      send(8'd30);
      send(8'd20);
      check_eq("fill_result", ifc.out_data, 20);

      // sliding, back-to-back
      ifc.in_valid = 1'b1;
      ifc.in_data = 8'd5;  tick(); check_eq("slide_1", ifc.out_data, 20);
      ifc.in_data = 8'd25; tick(); check_eq("slide_2", ifc.out_data, 20);
      ifc.in_data = 8'd25; tick(); check_eq("slide_3", ifc.out_data, 25);
      ifc.in_valid = 1'b0;
      tick();

      // backpressure: result pending, sink stalled
      ifc.out_ready = 1'b0;
      send(8'd40);
      ifc.in_valid = 1'b1;
      ifc.in_data  = 8'd50;
      for (int i = 0; i < 4; i++) tick();
      check_eq("bp_hold", ifc.out_data, 25);
      ifc.out_ready = 1'b1;
      tick();
      ifc.in_valid = 1'b0;
      tick();

      // flush with a pending result and a sample offered
      ifc.out_ready = 1'b0;
      send(8'd60);
      ifc.flush    = 1'b1;
      ifc.in_valid = 1'b1;
      ifc.in_data  = 8'd99;
      tick();
      ifc.flush    = 1'b0;
      ifc.in_valid = 1'b0;
      check_eq("flush_cnt", ifc.win_cnt, 0);
      ifc.out_ready = 1'b1;
      tick();
      base = n_results;
      send(8'd1);
      send(8'd2);
      check_eq("flush_no_result", n_results - base, 0);
      send(8'd3);

      // extremes and ties
      tick();
      send(8'd255); send(8'd0); send(8'd255);
      check_eq("extreme", ifc.out_data, 255);
      send(8'd0); send(8'd0); send(8'd1);
      check_eq("tie", ifc.out_data, 0);

      // async reset between edges with a result pending
      ifc.out_ready = 1'b0;
      send(8'd7);
      check_eq("pre_rst_valid", ifc.out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_out_valid", ifc.out_valid, 0);
      check_eq("async_win_cnt", ifc.win_cnt, 0);
      check_eq("async_in_ready", ifc.in_ready, 1);
      model_clear();
      @(negedge clk);
      ifc.out_ready = 1'b1;
      send(8'd77);
      rst = 1'b0;
      base = n_results;
      send(8'd9);
      send(8'd8);
      check_eq("post_rst_no_result", n_results - base, 0);
      send(8'd4);
      check_eq("post_rst_result", ifc.out_data, 8);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         ifc.in_valid  = ($urandom_range(0, 3) != 0);
         ifc.in_data   = 8'($urandom_range(0, 255));
         ifc.out_ready = ($urandom_range(0, 2) != 0);
         ifc.flush     = ($urandom_range(0, 19) == 0);
         tick();
      end
      ifc.flush = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
